// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern-detection controller:
// FSM state encoding, size defaults and the configuration legality rule.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;
    localparam int LEN_W_DEF   = $clog2(MAX_LEN_DEF + 1);
    localparam int MIN_LEN     = 2;

    // A configuration is usable when the length fits the history and at
    // least one match is requested (a zero target could never complete).
    function automatic logic cfg_is_legal(input int unsigned len,
                                          input int unsigned max_len,
                                          input logic        target_nonzero);
        return (len >= MIN_LEN) && (len <= max_len) && target_nonzero;
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Configuration, serial lane and status signals of the detection controller.
// The master side is the config front end / stream source, the slave side
// is the controller itself.
interface seq_detect_ctrl_if
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               start;
    logic               abort;
    logic               din_valid;
    logic               din;
    logic               hit;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output start, abort, din_valid, din,
        input  cfg_ready, hit, match_cnt, busy, done, err
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  start, abort, din_valid, din,
        output cfg_ready, hit, match_cnt, busy, done, err
    );
endinterface

// File: rtl/seq_pat_match.sv
// History shift register, fill counter and length-masked pattern compare.
// match is combinational and describes the beat being presented now, i.e.
// it looks at the history as it will be after shifting din in.
module seq_pat_match
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               shift_en,
    input  logic               clr,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic               din,
    output logic               match
);

    logic [MAX_LEN-1:0] hist_reg;
    logic [LEN_W-1:0]   fill_reg;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic [MAX_LEN-1:0] len_mask;

    // Only the low len bits of history/pattern take part in the compare.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign len_mask[gi] = (LEN_W'(gi) < len);
        end
    endgenerate

    assign hist_next = {hist_reg[MAX_LEN-2:0], din};
    assign fill_next = (fill_reg < len) ? (fill_reg + LEN_W'(1)) : len;

    // Match needs a full window of fresh bits so stale history never matches.
    always_comb begin
        match = shift_en && (fill_next >= len)
                && (((hist_next ^ pattern) & len_mask) == '0);
    end

    // History and fill update; clear wins over a simultaneous shift.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (clr) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (shift_en) begin
            hist_reg <= hist_next;
            fill_reg <= fill_next;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern-detection controller: accepts a configuration,
// arms, runs detection over qualified serial beats and stops at a target count.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    seq_detect_ctrl_if.slave    bus
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    state_t             state_reg, state_next;
    logic [MAX_LEN-1:0] pattern_reg;
    logic [LEN_W-1:0]   len_reg;
    logic               overlap_reg;
    logic [CNT_W-1:0]   target_reg;
    logic [CNT_W-1:0]   match_cnt_reg, match_cnt_next;
    logic               hit_reg, hit_next;
    logic               err_reg, err_next;

    logic               cfg_ready_c;
    logic               handshake;
    logic               cfg_legal;
    logic               load_cfg;
    logic               clr_run;
    logic               shift_en;
    logic               match;
    logic               pm_clr;
    logic [CNT_W-1:0]   cnt_inc;

    assign cfg_ready_c = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign handshake   = bus.cfg_valid && cfg_ready_c;
    assign cfg_legal   = cfg_is_legal(32'(bus.cfg_len), MAX_LEN, (bus.cfg_target != '0));
    assign cnt_inc     = match_cnt_reg + CNT_W'(1);

    // Without overlap, a match restarts the window so bits are not reused.
    assign pm_clr = clr_run || (match && !overlap_reg);

    seq_pat_match #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_match (
        .clk      (clk),
        .rstn     (rstn),
        .shift_en (shift_en),
        .clr      (pm_clr),
        .len      (len_reg),
        .pattern  (pattern_reg),
        .din      (bus.din),
        .match    (match)
    );

    // State and output registers, config capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            pattern_reg   <= '0;
            len_reg       <= '0;
            overlap_reg   <= 1'b0;
            target_reg    <= '0;
            match_cnt_reg <= '0;
            hit_reg       <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            match_cnt_reg <= match_cnt_next;
            hit_reg       <= hit_next;
            err_reg       <= err_next;
            if (load_cfg) begin
                pattern_reg <= bus.cfg_pattern;
                len_reg     <= bus.cfg_len;
                overlap_reg <= bus.cfg_overlap;
                target_reg  <= bus.cfg_target;
            end
        end
    end

    // Next-state and control: abort > config handshake > start > data beat.
    always_comb begin
        state_next     = state_reg;
        match_cnt_next = match_cnt_reg;
        hit_next       = 1'b0;
        err_next       = 1'b0;
        load_cfg       = 1'b0;
        clr_run        = 1'b0;
        shift_en       = 1'b0;

        if (bus.abort) begin
            state_next = ST_IDLE;
        end else if (handshake) begin
            if (cfg_legal) begin
                load_cfg   = 1'b1;
                state_next = ST_ARMED;
            end else begin
                err_next = 1'b1;
            end
        end else begin
            unique case (state_reg)
                ST_IDLE: ;
                ST_ARMED, ST_DONE: begin
                    // Beats arriving alongside start are not part of the run.
                    if (bus.start) begin
                        clr_run        = 1'b1;
                        match_cnt_next = '0;
                        state_next     = ST_RUN;
                    end
                end
                ST_RUN: begin
                    shift_en = bus.din_valid;
                    if (match) begin
                        hit_next       = 1'b1;
                        match_cnt_next = cnt_inc;
                        if (cnt_inc == target_reg) begin
                            state_next = ST_DONE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign bus.cfg_ready = cfg_ready_c;
    assign bus.hit       = hit_reg;
    assign bus.match_cnt = match_cnt_reg;
    assign bus.busy      = (state_reg == ST_RUN);
    assign bus.done      = (state_reg == ST_DONE);
    assign bus.err       = err_reg;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: overlap/non-overlap runs, target stop,
// illegal configs, valid gaps, start/abort collisions and async reset.
module tb_seq_detect_ctrl;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    seq_detect_ctrl_if #(.MAX_LEN(8), .CNT_W(8)) bus ();

    seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [0:21] stream = 22'b0001100110110110100110;
    logic [31:0] hits;
    logic [31:0] dones;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled on the negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len,
                          input logic ov, input logic [7:0] tgt);
        bus.cfg_valid   = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_overlap = ov;
        bus.cfg_target  = tgt;
        tick();
        bus.cfg_valid = 1'b0;
        $display("[TB] cfg pat=%b len=%0d ov=%0d tgt=%0d -> err=%0d ready=%0d",
                 pat, len, ov, tgt, bus.err, bus.cfg_ready);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        $display("[TB] start -> busy=%0d cnt=%0d", bus.busy, bus.match_cnt);
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        $display("[TB] abort -> ready=%0d cnt=%0d", bus.cfg_ready, bus.match_cnt);
    endtask

    task automatic beat(input logic v, input logic d);
        bus.din_valid = v;
        bus.din       = d;
        tick();
        bus.din_valid = 1'b0;
        $display("[TB] beat v=%0d d=%0d -> hit=%0d cnt=%0d", v, d, bus.hit, bus.match_cnt);
    endtask

    task automatic run_stream();
        hits  = '0;
        dones = '0;
        for (int i = 0; i < 22; i++) begin
            bus.din_valid = 1'b1;
            bus.din       = stream[i];
            tick();
            hits[i]  = bus.hit;
            dones[i] = bus.done;
        end
        bus.din_valid = 1'b0;
        $display("[TB] stream -> hits=%h dones=%h cnt=%0d", hits, dones, bus.match_cnt);
    endtask

    initial begin
        bus.cfg_valid   = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_overlap = 1'b0;
        bus.cfg_target  = '0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.din_valid   = 1'b0;
        bus.din         = 1'b0;
        rstn            = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready", bus.cfg_ready, 1);
        check("rst_hit",   bus.hit,       0);
        check("rst_cnt",   bus.match_cnt, 0);
        check("rst_busy",  bus.busy,      0);
        check("rst_done",  bus.done,      0);
        check("rst_err",   bus.err,       0);
        rstn = 1'b1;
        tick();

        // Illegal configs pulse err for one cycle and stay in IDLE
        do_cfg(8'b0000_0001, 4'd1, 1'b1, 8'd3);
        check("ill1_err",   bus.err,       1);
        check("ill1_ready", bus.cfg_ready, 1);
        tick();
        check("ill1_err_clr", bus.err, 0);
        do_cfg(8'b0000_0000, 4'd0, 1'b1, 8'd0);
        check("ill2_err",   bus.err,       1);
        check("ill2_ready", bus.cfg_ready, 1);
        tick();
        check("ill2_err_clr", bus.err, 0);

        // Overlap run, target 3: hits after beats 13 and 16
        do_cfg(8'b0010_1101, 4'd6, 1'b1, 8'd3);
        check("arm_ready", bus.cfg_ready, 0);
        check("arm_busy",  bus.busy,      0);
        check("arm_err",   bus.err,       0);
        pulse_start();
        check("ov_busy", bus.busy, 1);
        run_stream();
        check("ov_hits",  hits,          32'h0001_2000);
        check("ov_dones", dones,         32'h0);
        check("ov_cnt",   bus.match_cnt, 2);
        check("ov_busy2", bus.busy,      1);
        pulse_abort();
        check("ab_ready", bus.cfg_ready, 1);
        check("ab_busy",  bus.busy,      0);
        check("ab_cnt",   bus.match_cnt, 2);

        // Non-overlap run: single hit after beat 13
        do_cfg(8'b0010_1101, 4'd6, 1'b0, 8'd3);
        pulse_start();
        check("no_cnt_clr", bus.match_cnt, 0);
        run_stream();
        check("no_hits", hits,          32'h0000_2000);
        check("no_cnt",  bus.match_cnt, 1);
        pulse_abort();

        // Target reached at beat 16; later beats ignored
        do_cfg(8'b0010_1101, 4'd6, 1'b1, 8'd2);
        pulse_start();
        run_stream();
        check("tg_hits",  hits,          32'h0001_2000);
        check("tg_dones", dones,         32'h003F_0000);
        check("tg_cnt",   bus.match_cnt, 2);
        check("tg_busy",  bus.busy,      0);
        check("tg_ready", bus.cfg_ready, 1);
        pulse_start();
        check("re_busy", bus.busy,      1);
        check("re_cnt",  bus.match_cnt, 0);
        check("re_done", bus.done,      0);
        run_stream();
        check("re_hits", hits,          32'h0001_2000);
        check("re_cnt2", bus.match_cnt, 2);

        // Handshake and start together in DONE: handshake wins -> ARMED
        bus.start = 1'b1;
        do_cfg(8'b0000_0011, 4'd2, 1'b1, 8'd10);
        bus.start = 1'b0;
        check("hs_win_busy",  bus.busy,      0);
        check("hs_win_ready", bus.cfg_ready, 0);
        check("hs_win_done",  bus.done,      0);

        // Start with a coincident valid 1-bit: that bit is dropped
        bus.din_valid = 1'b1;
        bus.din       = 1'b1;
        pulse_start();
        bus.din_valid = 1'b0;
        check("gp_busy", bus.busy, 1);
        beat(1'b1, 1'b1);
        check("gp_drop_hit", bus.hit, 0);
        beat(1'b0, 1'b1);
        check("gp_gap1_hit", bus.hit, 0);
        beat(1'b1, 1'b1);
        check("gp_m1_hit", bus.hit,       1);
        check("gp_m1_cnt", bus.match_cnt, 1);
        beat(1'b0, 1'b0);
        check("gp_gap2_hit", bus.hit, 0);
        beat(1'b1, 1'b1);
        check("gp_m2_hit", bus.hit,       1);
        check("gp_m2_cnt", bus.match_cnt, 2);
        beat(1'b1, 1'b0);
        check("gp_zero_hit", bus.hit, 0);
        beat(1'b0, 1'b1);
        check("gp_gap3_hit", bus.hit, 0);
        beat(1'b1, 1'b1);
        check("gp_01_hit", bus.hit, 0);
        beat(1'b1, 1'b1);
        check("gp_m3_hit", bus.hit,       1);
        check("gp_m3_cnt", bus.match_cnt, 3);

        // Abort on a matching beat: no hit, count held, IDLE
        bus.abort = 1'b1;
        beat(1'b1, 1'b1);
        bus.abort = 1'b0;
        check("abm_hit",   bus.hit,       0);
        check("abm_cnt",   bus.match_cnt, 3);
        check("abm_ready", bus.cfg_ready, 1);
        check("abm_busy",  bus.busy,      0);

        // Async reset mid-run
        do_cfg(8'b0000_0011, 4'd2, 1'b1, 8'd10);
        pulse_start();
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b1);
        check("ar_pre_hit", bus.hit,       1);
        check("ar_pre_cnt", bus.match_cnt, 1);
        #1 rstn = 1'b0;
        #1;
        $display("[TB] async reset -> hit=%0d cnt=%0d busy=%0d", bus.hit, bus.match_cnt, bus.busy);
        check("ar_hit",   bus.hit,       0);
        check("ar_cnt",   bus.match_cnt, 0);
        check("ar_busy",  bus.busy,      0);
        check("ar_done",  bus.done,      0);
        check("ar_ready", bus.cfg_ready, 1);
        check("ar_err",   bus.err,       0);
        #1 rstn = 1'b1;
        tick();
        pulse_start();
        check("ar_start_ignored", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
